// File: rtl/video_color_xform_core_if.sv
// Frame-control type and the register/pixel bus bundle
// shared by the colour transform core and its users.
package vga_pkg;

  typedef struct packed {
    logic vsync;
    logic hsync;
    logic de;
  } vga_fc_t;

endpackage

interface video_color_xform_core_if #(
  parameter int RGB_SIZE = 12
);
  import vga_pkg::*;

  logic                avs_write;
  logic                avs_read;
  logic [1:0]          avs_address;
  logic [31:0]         avs_writedata;
  logic [31:0]         avs_readdata;

  logic                src_vld;
  logic                src_rdy;
  vga_fc_t             src_fc;
  logic [RGB_SIZE-1:0] src_rgb;

  logic                snk_rdy;
  logic                snk_vld;
  vga_fc_t             snk_fc;
  logic [RGB_SIZE-1:0] snk_rgb;

  modport master (
    output avs_write,
    output avs_read,
    output avs_address,
    output avs_writedata,
    input  avs_readdata,
    output src_vld,
    input  src_rdy,
    output src_fc,
    output src_rgb,
    output snk_rdy,
    input  snk_vld,
    input  snk_fc,
    input  snk_rgb
  );

  modport slave (
    input  avs_write,
    input  avs_read,
    input  avs_address,
    input  avs_writedata,
    output avs_readdata,
    input  src_vld,
    output src_rdy,
    input  src_fc,
    input  src_rgb,
    input  snk_rdy,
    output snk_vld,
    output snk_fc,
    output snk_rgb
  );

endinterface

// File: rtl/video_color_xform_core.sv
// Two-stage elastic RGB colour transform: bypass/gray/invert/threshold.
// Threshold mode exists only with VIDEO_COLOR_XFORM_THRESH_EN defined.
module video_color_xform_core
  import vga_pkg::*;
#(
  parameter int RSIZE    = 4,
  parameter int GSIZE    = 4,
  parameter int BSIZE    = 4,
  parameter int RGB_SIZE = 12
) (
  input  logic clk,
  input  logic rst_n,
  video_color_xform_core_if.slave bus
);

  localparam logic [1:0] M_GRAY   = 2'd1;
  localparam logic [1:0] M_INVERT = 2'd2;
  localparam logic [1:0] M_THRESH = 2'd3;

  logic [1:0]  mode;
  logic [7:0]  thresh;
  logic [31:0] pix_cnt;

  logic wr_ctrl;
  logic wr_cnt;
  logic out_hs;

  logic s1_vld;
  logic s1_ld;
  logic s2_vld;
  logic s2_ld;

  logic [RGB_SIZE-1:0] s1_rgb;
  vga_fc_t             s1_fc;
  logic [1:0]          s1_mode;
  logic [7:0]          s1_y;

  logic [RGB_SIZE-1:0] s2_rgb;
  vga_fc_t             s2_fc;

  logic [RSIZE-1:0] src_r;
  logic [GSIZE-1:0] src_g;
  logic [BSIZE-1:0] src_b;
  logic [7:0]       r8;
  logic [7:0]       g8;
  logic [7:0]       b8;
  logic [15:0]      y_sum;
  logic [7:0]       y8;

  logic [RGB_SIZE-1:0] gray_rgb;
  logic [RGB_SIZE-1:0] xf_rgb;

  logic unused;

  assign wr_ctrl = bus.avs_write
                && (bus.avs_address == 2'd0);
  assign wr_cnt  = bus.avs_write
                && (bus.avs_address == 2'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= '0;
    end else if (wr_ctrl) begin
      mode <= bus.avs_writedata[1:0];
    end
  end

`ifdef VIDEO_COLOR_XFORM_THRESH_EN
  logic wr_thr;
  logic s1_hit;

  assign wr_thr = bus.avs_write
               && (bus.avs_address == 2'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thresh <= '0;
    end else if (wr_thr) begin
      thresh <= bus.avs_writedata[7:0];
    end
  end

  // Compare against the threshold sampled with the pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_hit <= 1'b0;
    end else if (s1_ld && bus.src_vld) begin
      s1_hit <= (y8 >= thresh);
    end
  end

  assign unused = ^{bus.avs_read,
                    bus.avs_writedata[31:8],
                    y_sum[7:0], s1_y};
`else
  assign thresh = '0;

  assign unused = ^{bus.avs_read,
                    bus.avs_writedata[31:2],
                    y_sum[7:0], s1_y};
`endif

  // A clear landing on an output handshake wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt <= '0;
    end else if (wr_cnt) begin
      pix_cnt <= '0;
    end else if (out_hs) begin
      pix_cnt <= pix_cnt + 32'd1;
    end
  end

  always_comb begin
    bus.avs_readdata = '0;
    case (bus.avs_address)
      2'd0:    bus.avs_readdata[1:0] = mode;
      2'd1:    bus.avs_readdata[7:0] = thresh;
      2'd2:    bus.avs_readdata      = pix_cnt;
      default: bus.avs_readdata      = '0;
    endcase
  end

  assign src_r = bus.src_rgb[RGB_SIZE-1 -: RSIZE];
  assign src_g = bus.src_rgb[BSIZE +: GSIZE];
  assign src_b = bus.src_rgb[0 +: BSIZE];

  assign r8 = 8'(src_r) << (8 - RSIZE);
  assign g8 = 8'(src_g) << (8 - GSIZE);
  assign b8 = 8'(src_b) << (8 - BSIZE);

  // Max sum is 256*255, so 16 bits never overflow
  assign y_sum = 16'(r8) * 16'd77
               + 16'(g8) * 16'd150
               + 16'(b8) * 16'd29;
  assign y8 = y_sum[15:8];

  assign s2_ld = !s2_vld || bus.snk_rdy;
  assign s1_ld = !s1_vld || s2_ld;
  assign out_hs = s2_vld && bus.snk_rdy;

  assign bus.src_rdy = s1_ld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_rgb  <= '0;
      s1_fc   <= '0;
      s1_mode <= '0;
      s1_y    <= '0;
    end else if (s1_ld) begin
      s1_vld <= bus.src_vld;
      if (bus.src_vld) begin
        s1_rgb  <= bus.src_rgb;
        s1_fc   <= bus.src_fc;
        s1_mode <= mode;
        s1_y    <= y8;
      end
    end
  end

  assign gray_rgb = {s1_y[7 -: RSIZE],
                     s1_y[7 -: GSIZE],
                     s1_y[7 -: BSIZE]};

  always_comb begin
    xf_rgb = s1_rgb;
    case (s1_mode)
      M_GRAY:   xf_rgb = gray_rgb;
      M_INVERT: xf_rgb = ~s1_rgb;
`ifdef VIDEO_COLOR_XFORM_THRESH_EN
      M_THRESH: xf_rgb = s1_hit ? '1 : '0;
`else
      M_THRESH: xf_rgb = s1_rgb;
`endif
      default:  xf_rgb = s1_rgb;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld <= 1'b0;
      s2_rgb <= '0;
      s2_fc  <= '0;
    end else if (s2_ld) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_rgb <= xf_rgb;
        s2_fc  <= s1_fc;
      end
    end
  end

  assign bus.snk_vld = s2_vld;
  assign bus.snk_rgb = s2_rgb;
  assign bus.snk_fc  = s2_fc;

endmodule

// File: doc/video_color_xform_core.md
VIDEO_COLOR_XFORM_CORE -- requirements
Module: video_color_xform_core

Interface
REQ-001 SHALL have parameter RSIZE, default 4: red channel width, 1..8.
REQ-002 SHALL have parameter GSIZE, default 4: green channel width, 1..8.
REQ-003 SHALL have parameter BSIZE, default 4: blue channel width, 1..8.
REQ-004 SHALL have parameter RGB_SIZE, default 12: pixel width, equal to RSIZE+GSIZE+BSIZE; pixel packing is {R,G,B}, R in the MSBs.
REQ-005 SHALL have ports, in this order:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- avs_write  in  1  register write strobe.
- avs_read  in  1  register read strobe.
- avs_address  in  2  word address.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, combinational from avs_address.
- src_vld  in  1  input pixel valid.
- src_rdy  out  1  input pixel ready.
- src_fc  in  vga_fc_t  input frame control.
- src_rgb  in  RGB_SIZE  input pixel.
- snk_rdy  in  1  output ready.
- snk_vld  out  1  output valid.
- snk_fc  out  vga_fc_t  output frame control, aligned to snk_rgb.
- snk_rgb  out  RGB_SIZE  output pixel.

Function
REQ-006 SHALL provide registers: 0x0 ctrl, mode[1:0] (0 bypass, 1 gray, 2 invert, 3 threshold); 0x1 thresh[7:0]; 0x2 pix_cnt[31:0], read-only, cleared by any write to 0x2; 0x3 reads 0.
REQ-007 SHALL return unused readdata bits as 0.
REQ-008 SHALL implement a 2-stage elastic pipeline: stage k loads when its valid is 0 or stage k+1 (snk_rdy for stage 2) accepts.
REQ-009 SHALL drive src_rdy = !s1_vld | (!s2_vld | snk_rdy), with no combinational path from src_vld to src_rdy.
REQ-010 SHALL give latency exactly 2 cycles from src accept to snk_vld with snk_rdy held 1, at full throughput of 1 pixel/cycle.
REQ-011 SHALL hold snk_vld, snk_fc and snk_rgb stable while snk_vld=1 and snk_rdy=0.
REQ-012 SHALL sample mode and thresh into stage 1 with each accepted pixel; a register write affects only pixels accepted after the write cycle, never in-flight ones.
REQ-013 SHALL widen each channel to 8 bits by LSB zero-padding (c8 = c << (8-SIZE)).
REQ-014 SHALL compute Y8 = (77*R8 + 150*G8 + 29*B8) >> 8 using 16-bit unsigned arithmetic in stage 1; no overflow is possible.
REQ-015 SHALL in gray mode output each channel as Y8[7:8-SIZE].
REQ-016 SHALL in invert mode output the bitwise NOT of each channel.
REQ-017 SHALL in threshold mode output all ones when Y8 >= thresh, otherwise all zeros; thresh=0 yields all ones.
REQ-018 SHALL in bypass mode output src_rgb unchanged.
REQ-019 SHALL pass src_fc unchanged through both stages alongside the pixel.
REQ-020 SHALL increment pix_cnt on each snk_vld&snk_rdy cycle, wrapping 0xFFFFFFFF to 0.
REQ-021 SHALL clear pix_cnt to 0 when a write to 0x2 coincides with an output handshake; the clear wins.

Reset
REQ-022 SHALL asynchronously, on rst_n=0, clear mode, thresh, pix_cnt and both stage valids, giving snk_vld=0.
REQ-023 SHALL drive snk_rgb and snk_fc to 0 in reset.
REQ-024 SHALL drop in-flight pixels on reset mid-frame, and SHALL drive src_rdy=1 on the first cycle after reset release.

Configuration
REQ-025 SHALL use macro VIDEO_COLOR_XFORM_THRESH_EN:
- Defined: threshold mode and thresh register are present.
- Undefined: mode 3 behaves as bypass, thresh reads 0 and writes to it are ignored.

Verification
REQ-026 SHALL cover mode=1 with 4/4/4 params, src_rgb=0xFFF -> snk_rgb=0xFFF; src_rgb=0xF00 -> Y8=0x48, snk_rgb=0x444.
REQ-027 SHALL cover mode=2, src_rgb=0x1A5 -> snk_rgb=0xE5A exactly 2 cycles after acceptance.
REQ-028 SHALL cover mode=3, thresh=0x80: src 0x888 (Y8=0x80) -> 0xFFF; src 0x777 -> 0x000.
REQ-029 SHALL cover snk_rdy=0 for 5 cycles during a stream: src_rdy falls after 2 pixels are held, the held output stays stable, and there is no loss or duplication after release; pix_cnt equals the number of pixels sent.
REQ-030 SHALL cover a mode write from 0 to 2 while 2 pixels are in flight: those 2 pixels exit bypassed and the next pixel exits inverted.
REQ-031 SHALL cover rst_n pulsed low mid-stream: snk_vld=0 immediately, pix_cnt=0, and mode reads 0.
